// File: rtl/rr_arbiter_4_if.sv
// ----------------------------------------------------------------------------
// rr_arbiter_4_if
// Bundles the request/grant signals of the 4-requester round-robin arbiter.
//
// Signals:
//   req     [3:0]  request lines, bit i = requester i (level-sensitive)
//   done           current owner releases the grant
//   grant   [3:0]  registered one-hot grant, 0000 when idle
//   enable         one-cycle pulse in the first cycle of each new grant
//   busy           high while a grant is held
//   timeout        one-cycle pulse on a forced release
//
// Modports:
//   master  requester side (drives req/done, observes grant status)
//   slave   arbiter side (observes req/done, drives grant status)
// ----------------------------------------------------------------------------
interface rr_arbiter_4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       enable;
  logic       busy;
  logic       timeout;

  modport master (
    output req, done,
    input  grant, enable, busy, timeout
  );

  modport slave (
    input  req, done,
    output grant, enable, busy, timeout
  );
endinterface : rr_arbiter_4_if

// File: rtl/rr_arbiter_4.sv
// ----------------------------------------------------------------------------
// rr_arbiter_4
// Round-robin arbiter for four requesters. Produces a registered one-hot
// grant and a one-cycle enable pulse for the downstream 4-to-2 encoder.
// At most one grant bit is ever high, ownership rotates fairly starting
// after the last released owner, and every grant is followed by at least
// one idle cycle with grant = 0000.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   arb        rr_arbiter_4_if.slave: req, done in; grant, enable, busy,
//              timeout out
//
// Parameters:
//   MAX_HOLD   maximum consecutive grant cycles (only with ARB_TIMEOUT_EN)
//   CNT_W      hold-counter width, 1 <= MAX_HOLD <= 2**CNT_W-1
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   Defined:   a hold counter forces release after MAX_HOLD grant cycles
//              and pulses timeout coincident with grant returning to 0000.
//   Undefined: no counter; timeout is tied 0 and a grant is held until
//              done or the owner's request drops.
// ----------------------------------------------------------------------------
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  rr_arbiter_4_if.slave   arb
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  // Reject illegal parameter combinations at elaboration.
  if (MAX_HOLD < 1 || MAX_HOLD > (2 ** CNT_W) - 1) begin : g_bad_param
    $error("rr_arbiter_4: MAX_HOLD out of range for CNT_W");
  end

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_grant;
  logic       r_enable;
  logic       r_timeout;
  logic [1:0] r_last;

  logic [1:0] w_pick_idx;
  logic [1:0] w_owner_idx;
  logic       w_normal_rel;
  logic       w_force_rel;
  logic       w_release;
  logic       w_busy;

  // --------------------------------------------------------------------------
  // Circular priority scan starting at (last+1) mod 4.
  // --------------------------------------------------------------------------
  always_comb begin
    logic       found;
    logic [1:0] idx;
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise synthesis infers a latch to hold the old value.
    w_pick_idx = 2'd0;
    found      = 1'b0;
    idx        = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = r_last + 2'(i + 1);
      if (!found && arb.req[idx]) begin
        w_pick_idx = idx;
        found      = 1'b1;
      end
    end
  end

  // Index of the current owner, decoded from the one-hot grant.
  always_comb begin
    w_owner_idx = 2'd0;
    unique case (r_grant)
      4'b0010: w_owner_idx = 2'd1;
      4'b0100: w_owner_idx = 2'd2;
      4'b1000: w_owner_idx = 2'd3;
      default: w_owner_idx = 2'd0;
    endcase
  end

  assign w_normal_rel = arb.done | ~arb.req[w_owner_idx];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_hold_cnt;

  // Forced release only when no ordinary release applies this cycle.
  assign w_force_rel = (r_hold_cnt == CNT_W'(MAX_HOLD)) & ~w_normal_rel;

  // Counter reads 1 in the first grant cycle, so a release fires after
  // exactly MAX_HOLD cycles of grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_hold_cnt <= (|arb.req) ? CNT_W'(1) : '0;
    end else if (w_release) begin
      r_hold_cnt <= '0;
    end else begin
      r_hold_cnt <= r_hold_cnt + CNT_W'(1);
    end
  end
`else
  assign w_force_rel = 1'b0;
`endif

  assign w_release = w_normal_rel | w_force_rel;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (|arb.req)  w_state_nxt = S_GRANT;
      S_GRANT: if (w_release) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: output logic
  always_comb begin
    w_busy = (r_state == S_GRANT);
  end

  // --------------------------------------------------------------------------
  // Registered grant datapath. done in IDLE is ignored; a release always
  // lands in IDLE, which guarantees the idle cycle between owners.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant   <= 4'b0000;
      r_enable  <= 1'b0;
      r_timeout <= 1'b0;
      r_last    <= 2'd3;
    end else begin
      r_enable  <= 1'b0;
      r_timeout <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (|arb.req) begin
            r_grant  <= 4'b0001 << w_pick_idx;
            r_enable <= 1'b1;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_grant   <= 4'b0000;
            r_last    <= w_owner_idx;
            r_timeout <= w_force_rel;
          end
        end
        default: r_grant <= 4'b0000;
      endcase
    end
  end

  assign arb.grant   = r_grant;
  assign arb.enable  = r_enable;
  assign arb.busy    = w_busy;
  assign arb.timeout = r_timeout;

endmodule : rr_arbiter_4

// File: tb/tb_rr_arbiter_4.sv
// ----------------------------------------------------------------------------
// tb_rr_arbiter_4
// Directed testbench for rr_arbiter_4. Inputs change 1 ns after a rising
// edge; outputs are sampled at that same point, away from the active edge.
// Built with MAX_HOLD = 3 so the timeout scenario is short when
// ARB_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rr_arbiter_4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  rr_arbiter_4_if arb_if ();

  rr_arbiter_4 #(
    .MAX_HOLD (3),
    .CNT_W    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .arb (arb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and check the always-true invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    n_checks++;
    if (!$onehot0(arb_if.grant)) begin
      n_errors++;
      $display("FAIL onehot0: grant=%b required one-hot or zero", arb_if.grant);
    end
    n_checks++;
    if (arb_if.enable && arb_if.grant === 4'b0000) begin
      n_errors++;
      $display("FAIL enable_implies_grant: enable=1 grant=%b required nonzero",
               arb_if.grant);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    arb_if.req  = 4'b0000;
    arb_if.done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    arb_if.req  = 4'b1111;
    arb_if.done = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (arb_if.grant !== 4'b0000 || arb_if.enable !== 1'b0 ||
          arb_if.busy !== 1'b0 || arb_if.timeout !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_hold: grant=%b en=%b busy=%b to=%b required 0000 0 0 0",
                 arb_if.grant, arb_if.enable, arb_if.busy, arb_if.timeout);
      end
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (arb_if.grant !== 4'b0001 || arb_if.enable !== 1'b1 || arb_if.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_first_grant: grant=%b en=%b busy=%b required 0001 1 1",
               arb_if.grant, arb_if.enable, arb_if.busy);
    end
    tick();
    n_checks++;
    if (arb_if.grant !== 4'b0001 || arb_if.enable !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_enable_once: grant=%b en=%b required 0001 0",
               arb_if.grant, arb_if.enable);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_seq [9];
    exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    do_reset();
    arb_if.req = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      tick();
      n_checks++;
      if (arb_if.grant !== exp_seq[k] || arb_if.enable !== (exp_seq[k] != 4'b0000)) begin
        n_errors++;
        $display("FAIL rotation[%0d]: grant=%b en=%b required %b %b", k,
                 arb_if.grant, arb_if.enable, exp_seq[k], exp_seq[k] != 4'b0000);
      end
      arb_if.done = (exp_seq[k] != 4'b0000);
    end
    arb_if.done = 1'b0;
    arb_if.req  = 4'b0000;
    tick();
  endtask

  task automatic test_owner_drop();
    do_reset();
    arb_if.req = 4'b0100;
    tick();
    n_checks++;
    if (arb_if.grant !== 4'b0100) begin
      n_errors++;
      $display("FAIL drop_grant: grant=%b required 0100", arb_if.grant);
    end
    arb_if.req = 4'b0000;
    tick();
    n_checks++;
    if (arb_if.grant !== 4'b0000 || arb_if.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL drop_release: grant=%b busy=%b required 0000 0",
               arb_if.grant, arb_if.busy);
    end
    tick();
    arb_if.req = 4'b0101;
    tick();
    n_checks++;
    if (arb_if.grant !== 4'b0001) begin
      n_errors++;
      $display("FAIL drop_rescan: grant=%b required 0001", arb_if.grant);
    end
    arb_if.req = 4'b0000;
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    arb_if.req = 4'b0010;
    tick();
    n_checks++;
    if (arb_if.grant !== 4'b0010) begin
      n_errors++;
      $display("FAIL simul_owner: grant=%b required 0010", arb_if.grant);
    end
    arb_if.req  = 4'b1010;
    arb_if.done = 1'b1;
    tick();
    n_checks++;
    if (arb_if.grant !== 4'b0000 || arb_if.enable !== 1'b0) begin
      n_errors++;
      $display("FAIL simul_release: grant=%b en=%b required 0000 0",
               arb_if.grant, arb_if.enable);
    end
    arb_if.done = 1'b0;
    tick();
    n_checks++;
    if (arb_if.grant !== 4'b1000 || arb_if.enable !== 1'b1) begin
      n_errors++;
      $display("FAIL simul_regrant: grant=%b en=%b required 1000 1",
               arb_if.grant, arb_if.enable);
    end
    tick();
    n_checks++;
    if (arb_if.grant !== 4'b1000 || arb_if.enable !== 1'b0) begin
      n_errors++;
      $display("FAIL simul_enable_once: grant=%b en=%b required 1000 0",
               arb_if.grant, arb_if.enable);
    end
    arb_if.req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    arb_if.req = 4'b0010;
    tick();
    tick();
    n_checks++;
    if (arb_if.grant !== 4'b0010) begin
      n_errors++;
      $display("FAIL midrst_held: grant=%b required 0010", arb_if.grant);
    end
    rst        = 1'b1;
    arb_if.req = 4'b1111;
    tick();
    n_checks++;
    if (arb_if.grant !== 4'b0000 || arb_if.timeout !== 1'b0 || arb_if.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_clear: grant=%b to=%b busy=%b required 0000 0 0",
               arb_if.grant, arb_if.timeout, arb_if.busy);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (arb_if.grant !== 4'b0001) begin
      n_errors++;
      $display("FAIL midrst_next: grant=%b required 0001", arb_if.grant);
    end
    arb_if.req = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    arb_if.req  = 4'b0001;
    arb_if.done = 1'b0;
`ifdef ARB_TIMEOUT_EN
    begin
      // Three grant cycles, one released cycle with timeout, then regrant.
      logic [3:0] exp_g  [5];
      logic       exp_to [5];
      exp_g  = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
      exp_to = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 5; k++) begin
        tick();
        n_checks++;
        if (arb_if.grant !== exp_g[k] || arb_if.timeout !== exp_to[k]) begin
          n_errors++;
          $display("FAIL timeout[%0d]: grant=%b to=%b required %b %b", k,
                   arb_if.grant, arb_if.timeout, exp_g[k], exp_to[k]);
        end
      end
    end
`else
    for (int k = 0; k < 22; k++) begin
      tick();
      n_checks++;
      if (arb_if.grant !== 4'b0001 || arb_if.timeout !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_forever[%0d]: grant=%b to=%b required 0001 0", k,
                 arb_if.grant, arb_if.timeout);
      end
    end
`endif
    arb_if.req = 4'b0000;
    tick();
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    arb_if.req  = 4'b0000;
    arb_if.done = 1'b0;
    #1;
    test_reset();
    test_rotation();
    test_owner_drop();
    test_simultaneous();
    test_reset_mid_grant();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_rr_arbiter_4
